// File: rtl/bm_buf_scheduler.sv
// Ping-pong frame-buffer scheduler: grants the writer the next buffer in strict
// alternation, drops frames that would hit a busy buffer, tracks consumer reads.
module bm_buf_scheduler #(
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_frame_start,
  input  logic             wr_frame_done,
  output logic             wr_grant,
  output logic             wr_skip,
  output logic             wr_buf,
  output logic [3:0]       img_number_out,
  input  logic             bm_idle,
  input  logic             bm_working_buf,
  output logic [1:0]       buf_busy,
  output logic [cnt_w-1:0] drop_count,
  output logic             proto_err
);

  localparam logic [1:0] B_FREE    = 2'd0;
  localparam logic [1:0] B_WRITING = 2'd1;
  localparam logic [1:0] B_READY   = 2'd2;
  localparam logic [1:0] B_READING = 2'd3;
  localparam logic       W_IDLE    = 1'b0;
  localparam logic       W_WRITE   = 1'b1;

  logic            w_state;
  logic [1:0][1:0] buf_st, buf_nxt;
  logic            bm_idle_q, rd_buf;
  logic            tgt, do_grant, do_skip, do_done, rd_fall, rd_rise, proto_hit;

  // The controller reads buffer img_number[0], so the writer must follow it.
  assign tgt      = img_number_out[0];
  assign do_grant = (w_state == W_IDLE)  && wr_frame_start && (buf_st[tgt] == B_FREE);
  assign do_skip  = (w_state == W_IDLE)  && wr_frame_start && (buf_st[tgt] != B_FREE);
  assign do_done  = (w_state == W_WRITE) && wr_frame_done;
  assign rd_fall  = bm_idle_q && !bm_idle;
  assign rd_rise  = !bm_idle_q && bm_idle;

  assign proto_hit = ((w_state == W_WRITE) && wr_frame_start) ||
                     ((w_state == W_IDLE)  && wr_frame_done)  ||
                     (rd_fall && (buf_st[bm_working_buf] != B_READY));

  // Writer and consumer updates never collide on the same buffer transition,
  // so each buffer's next state simply folds in both sides.
  always_comb begin
    buf_nxt = buf_st;
    for (int b = 0; b < 2; b++) begin
      if (do_grant && (int'(tgt) == b))            buf_nxt[b] = B_WRITING;
      if (do_done  && (int'(wr_buf) == b))         buf_nxt[b] = B_READY;
      if (rd_fall  && (int'(bm_working_buf) == b)) buf_nxt[b] = B_READING;
      if (rd_rise  && (int'(rd_buf) == b))         buf_nxt[b] = B_FREE;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_busy
    assign buf_busy[b] = (buf_st[b] != B_FREE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state        <= W_IDLE;
      buf_st         <= '0;
      bm_idle_q      <= 1'b1;
      rd_buf         <= 1'b0;
      wr_grant       <= 1'b0;
      wr_skip        <= 1'b0;
      wr_buf         <= 1'b0;
      img_number_out <= 4'd0;
      drop_count     <= '0;
      proto_err      <= 1'b0;
    end else begin
      buf_st    <= buf_nxt;
      bm_idle_q <= bm_idle;
      wr_grant  <= do_grant;
      wr_skip   <= do_skip;
      if (do_grant) begin
        wr_buf  <= tgt;
        w_state <= W_WRITE;
      end
      if (do_done) begin
        img_number_out <= img_number_out + 4'd1;
        w_state        <= W_IDLE;
      end
      if (do_skip && (drop_count != '1)) drop_count <= drop_count + cnt_w'(1);
      if (rd_fall) rd_buf <= bm_working_buf;
      if (proto_hit) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bm_buf_scheduler.sv
// Directed bench for bm_buf_scheduler; a second instance with a 4-bit drop
// counter shares the stimulus to exercise saturation.
module tb_bm_buf_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_frame_start, wr_frame_done, bm_idle, bm_working_buf;
  logic        wr_grant, wr_skip, wr_buf, proto_err;
  logic [3:0]  img_number_out;
  logic [1:0]  buf_busy;
  logic [15:0] drop_count;
  logic        g4, s4, b4, p4;
  logic [3:0]  i4, d4;
  logic [1:0]  bb4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bm_buf_scheduler #(.cnt_w(16)) u_dut (
    .clk(clk), .reset(reset), .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
    .wr_grant(wr_grant), .wr_skip(wr_skip), .wr_buf(wr_buf), .img_number_out(img_number_out),
    .bm_idle(bm_idle), .bm_working_buf(bm_working_buf), .buf_busy(buf_busy),
    .drop_count(drop_count), .proto_err(proto_err)
  );

  bm_buf_scheduler #(.cnt_w(4)) u_dut4 (
    .clk(clk), .reset(reset), .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
    .wr_grant(g4), .wr_skip(s4), .wr_buf(b4), .img_number_out(i4),
    .bm_idle(bm_idle), .bm_working_buf(bm_working_buf), .buf_busy(bb4),
    .drop_count(d4), .proto_err(p4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_frame_start = 0; wr_frame_done = 0; bm_idle = 1; bm_working_buf = 0;
    #2 reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic start_pulse();
    wr_frame_start = 1; tick(); wr_frame_start = 0;
  endtask

  task automatic done_pulse();
    wr_frame_done = 1; tick(); wr_frame_done = 0;
  endtask

  task automatic consume(input logic b);
    bm_idle = 0; bm_working_buf = b; tick();
    bm_idle = 1; tick();
  endtask

  initial begin
    reset = 0;
    wr_frame_start = 0; wr_frame_done = 0; bm_idle = 1; bm_working_buf = 0;
    // reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      wr_frame_start = 1'($urandom_range(0, 1));
      wr_frame_done  = 1'($urandom_range(0, 1));
      bm_idle        = 1'($urandom_range(0, 1));
      bm_working_buf = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_grant", wr_grant, 0);
    chk("rst_skip",  wr_skip, 0);
    chk("rst_buf",   wr_buf, 0);
    chk("rst_img",   img_number_out, 0);
    chk("rst_busy",  buf_busy, 0);
    chk("rst_drop",  drop_count, 0);
    chk("rst_perr",  proto_err, 0);
    wr_frame_start = 0; wr_frame_done = 0; bm_idle = 1; bm_working_buf = 0;
    tick();
    reset = 1;
    tick();

    // first grant
    start_pulse();
    chk("g1_grant", wr_grant, 1);
    chk("g1_buf",   wr_buf, 0);
    chk("g1_busy",  buf_busy, 2'b01);
    tick();
    chk("g1_pulse", wr_grant, 0);
    done_pulse();
    chk("d1_img", img_number_out, 1);

    // second frame, then a skip
    start_pulse();
    chk("g2_grant", wr_grant, 1);
    chk("g2_buf",   wr_buf, 1);
    chk("g2_busy",  buf_busy, 2'b11);
    done_pulse();
    chk("d2_img", img_number_out, 2);
    start_pulse();
    chk("s3_skip",  wr_skip, 1);
    chk("s3_grant", wr_grant, 0);
    chk("s3_drop",  drop_count, 1);
    chk("s3_busy",  buf_busy, 2'b11);
    chk("s3_img",   img_number_out, 2);

    // consume buffer 0 and reuse it
    bm_idle = 0; bm_working_buf = 0; tick();
    chk("c_fall_busy", buf_busy, 2'b11);
    chk("c_fall_perr", proto_err, 0);
    bm_idle = 1; tick();
    chk("c_rise_busy", buf_busy, 2'b10);
    start_pulse();
    chk("c_grant", wr_grant, 1);
    chk("c_buf",   wr_buf, 0);
    done_pulse();
    chk("c_img", img_number_out, 3);

    // same-cycle free and start: skip, then grant next cycle
    bm_idle = 0; bm_working_buf = 1; tick();
    bm_idle = 1; wr_frame_start = 1; tick();
    chk("sc_skip",  wr_skip, 1);
    chk("sc_grant", wr_grant, 0);
    chk("sc_drop",  drop_count, 2);
    chk("sc_busy",  buf_busy, 2'b01);
    tick();
    wr_frame_start = 0;
    chk("sc2_grant", wr_grant, 1);
    chk("sc2_buf",   wr_buf, 1);
    done_pulse();
    chk("sc_img", img_number_out, 4);
    chk("sc_perr", proto_err, 0);

    // 17 frames with immediate consumer, from a fresh reset
    do_reset();
    tick();
    for (int k = 0; k < 17; k++) begin
      start_pulse();
      chk("w_grant", wr_grant, 1);
      chk("w_buf",   wr_buf, 32'(k % 2));
      done_pulse();
      consume(1'(k % 2));
    end
    chk("w_img",  img_number_out, 1);
    chk("w_busy", buf_busy, 0);
    chk("w_perr", proto_err, 0);

    // fill both buffers, then 20 forced skips
    start_pulse(); done_pulse();
    start_pulse(); done_pulse();
    chk("f_img",  img_number_out, 3);
    chk("f_busy", buf_busy, 2'b11);
    wr_frame_start = 1;
    for (int k = 0; k < 20; k++) tick();
    wr_frame_start = 0;
    chk("sat_skip",  wr_skip, 1);
    chk("sat_drop16", drop_count, 20);
    chk("sat_drop4",  d4, 15);
    tick();
    chk("sat_skip_end", wr_skip, 0);

    // start during W_WRITE
    consume(1);
    chk("p_busy", buf_busy, 2'b01);
    start_pulse();
    chk("p_grant", wr_grant, 1);
    start_pulse();
    chk("p_perr",   proto_err, 1);
    chk("p_grant2", wr_grant, 0);
    chk("p_skip",   wr_skip, 0);
    chk("p_drop",   drop_count, 20);
    done_pulse();
    chk("p_img", img_number_out, 4);

    // consumer starting on a FREE buffer
    do_reset();
    chk("r_perr", proto_err, 0);
    bm_idle = 0; bm_working_buf = 0; tick();
    chk("cf_perr", proto_err, 1);
    chk("cf_busy", buf_busy, 2'b01);
    bm_idle = 1; tick();
    chk("cf_busy2", buf_busy, 2'b00);
    tick(); tick();
    chk("cf_sticky", proto_err, 1);

    // done while idle
    do_reset();
    done_pulse();
    chk("di_perr", proto_err, 1);
    chk("di_img",  img_number_out, 0);
    reset = 0; #1;
    chk("async_clr", proto_err, 0);
    tick();
    reset = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
